// File: rtl/rv_mdu_seq.sv
// rv_mdu_seq: iterative RV32M multiply/divide unit.
// One shift-add or restoring-divide step per cycle.
package rv_mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } mdu_state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

endpackage

module rv_mdu_seq
  import rv_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q;
  mdu_op_t           op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   res_q;
  logic              valid_q;

  mdu_op_t         op_in;
  logic            div_in;
  logic            sa_in;
  logic            sb_in;
  logic            neg_in;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            fast_in;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_nxt;

  assign ready_o   = (state_q == S_IDLE);
  assign valid_o   = valid_q;
  assign result_o  = res_q;
  assign rd_addr_o = rd_q;

  // Request decode: operand signedness, magnitudes and early-out results
  always_comb begin
    op_in  = mdu_op_t'(op_i);
    div_in = op_i[2];
    sa_in  = 1'b0;
    sb_in  = 1'b0;
    unique case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        sa_in = 1'b1;
        sb_in = 1'b1;
      end
      OP_MULHSU: sa_in = 1'b1;
      default: ;
    endcase
    a_abs = (sa_in && a_i[XLEN-1]) ? -a_i : a_i;
    b_abs = (sb_in && b_i[XLEN-1]) ? -b_i : b_i;
    if (op_in == OP_REM)
      neg_in = a_i[XLEN-1];
    else
      neg_in = (sa_in & a_i[XLEN-1]) ^ (sb_in & b_i[XLEN-1]);
    fast_in = div_in && ((b_i == '0) ||
              (!op_i[0] && a_i == MIN && b_i == '1));
    if (b_i == '0)
      fast_res = op_i[1] ? a_i : '1;
    else
      fast_res = op_i[1] ? '0 : MIN;
  end

  // One iteration step plus sign fixup of the would-be final value
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, b_q};
    if (op_q[2]) begin
      if (div_diff[XLEN])
        acc_nxt = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = neg_q ? -acc_nxt[2*XLEN-1:XLEN]
                     : acc_nxt[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                       res_nxt = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_nxt = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_nxt = quo_fix;
      default:                      res_nxt = rem_fix;
    endcase
  end

  // Control FSM with registered result, valid and captured destination
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else if (kill_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_q  <= op_in;
            rd_q  <= rd_addr_i;
            a_q   <= a_abs;
            b_q   <= b_abs;
            neg_q <= neg_in;
            cnt_q <= '0;
            acc_q <= {{XLEN{1'b0}}, (div_in ? a_abs : b_abs)};
            if (fast_in) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              res_q   <= fast_res;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            res_q   <= res_nxt;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mdu_seq.sv
// tb_rv_mdu_seq: table-driven bench with a result scoreboard
// for the iterative RV32M multiply/divide unit.
module tb_rv_mdu_seq;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  rv_mdu_seq #(.XLEN(32)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .rd_addr_i (rd_addr_i),
    .kill_i    (kill_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd,
                       input logic [31:0] res,
                       input int lat,
                       input bit push);
    exp_t e;
    @(negedge clk);
    check("ready_before_req", 32'(ready_o), 32'd1);
    valid_i   = 1'b1;
    op_i      = op;
    a_i       = a;
    b_i       = b;
    rd_addr_i = rd;
    if (push) begin
      e.res = res;
      e.rd  = rd;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i   = 1'b0;
    a_i       = $urandom;
    b_i       = $urandom;
    op_i      = 3'($urandom);
    rd_addr_i = 5'($urandom);
  endtask

  task automatic collect();
    int cyc;
    exp_t e;
    cyc = 1;
    while (!valid_o && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!valid_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: valid_o 0 after %0d cycles", cyc);
      return;
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_valid: got result %h", result_o);
      return;
    end
    e = sb.pop_front();
    check("result", result_o, e.res);
    check("rd_addr", 32'(rd_addr_o), 32'(e.rd));
    check("latency", 32'(cyc), 32'(e.lat));
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
    check("hs_valid_low", 32'(valid_o), 32'd0);
    check("hs_ready_high", 32'(ready_o), 32'd1);
  endtask

  task automatic quiet(input int n, input string name);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001, 33};
    tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000, 33};
    tbl[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, 33};
    tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF, 33};
    tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd1, 32'hFFFFFFFD, 33};
    tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd2, 32'hFFFFFFFF, 33};
    tbl[6]  = '{3'b101, 32'd100,      32'd7,        5'd3, 32'd14,        33};
    tbl[7]  = '{3'b111, 32'd100,      32'd7,        5'd4, 32'd2,         33};
    tbl[8]  = '{3'b101, 32'd7,        32'd0,        5'd6, 32'hFFFFFFFF, 1};
    tbl[9]  = '{3'b110, 32'd7,        32'd0,        5'd7, 32'd7,         1};
    tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1};
    tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h00000000, 1};
    tbl[12] = '{3'b001, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000, 33};
    tbl[13] = '{3'b100, 32'hFFFFFF9C, 32'd7,        5'd11, 32'hFFFFFFF2, 33};
    tbl[14] = '{3'b110, 32'hFFFFFF9C, 32'd7,        5'd12, 32'hFFFFFFFE, 33};
    tbl[15] = '{3'b110, 32'd100,      32'hFFFFFFF9, 5'd31, 32'd2,        33};

    rst_ni = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_result", result_o, 32'd0);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_ready", 32'(ready_o), 32'd1);
      check("idle_valid", 32'(valid_o), 32'd0);
      check("idle_result", result_o, 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd,
            tbl[i].res, tbl[i].lat, 1'b1);
      collect();
      handshake();
    end

    ready_i = 1'b0;
    issue(3'b000, 32'd3, 32'd4, 5'd9, 32'd12, 33, 1'b1);
    collect();
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_result", result_o, 32'd12);
      check("bp_rd", 32'(rd_addr_o), 32'd9);
      check("bp_ready", 32'(ready_o), 32'd0);
      check("bp_valid", 32'(valid_o), 32'd1);
    end
    @(negedge clk);
    ready_i = 1'b1;
    handshake();

    issue(3'b100, 32'd1000, 32'd3, 5'd7, 32'd0, 0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_valid", 32'(valid_o), 32'd0);
    quiet(40, "kill_no_result");

    @(negedge clk);
    valid_i = 1'b1;
    kill_i  = 1'b1;
    op_i    = 3'b000;
    a_i     = 32'd2;
    b_i     = 32'd2;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    check("kill_blocks_accept", 32'(ready_o), 32'd1);
    quiet(40, "kill_accept_no_result");

    issue(3'b000, 32'd6, 32'd7, 5'd13, 32'd42, 33, 1'b1);
    collect();
    handshake();

    issue(3'b000, 32'd5, 32'd5, 5'd14, 32'd25, 33, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    quiet(40, "arst_no_result");

    issue(3'b000, 32'd9, 32'd9, 5'd15, 32'd81, 33, 1'b1);
    collect();
    handshake();

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
